serial_shift_drv: RTL and testbench



---
 rtl/serial_shift_pkg.sv | 35 +++
 rtl/serial_shift_tick.sv | 60 ++++++
 rtl/serial_shift_drv.sv | 188 ++++++++++++++++++
 tb/tb_serial_shift_drv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_shift_pkg.sv
// Shared definitions for the serial shift-out driver.
//   - ss_state_e : frame sequencer states
//   - ss_clog2   : ceil(log2(val)), 0 for val <= 1
//   - ss_cnt_w   : width of a down/up counter that must hold max(a, b) - 1, at least 1 bit
package serial_shift_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } ss_state_e;

  localparam int unsigned SsDefDataW  = 64;
  localparam int unsigned SsDefClkDiv = 4;

  function automatic int unsigned ss_clog2(input int unsigned val);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  function automatic int unsigned ss_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = ss_clog2(m);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_shift_tick.sv
// Half-period timer for the serial clock.
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_en        count enable (frame active); when low the counter and phase are held at 0
//   i_phase_en  allow o_phase to toggle on each half tick (shifting only)
//   o_half_tick one-cycle pulse every CLK_DIV enabled cycles
//   o_phase     serial clock phase, registered
module serial_shift_tick
  import serial_shift_pkg::*;
#(
  parameter int unsigned CLK_DIV = SsDefClkDiv,
  parameter int unsigned CNT_W   = ss_cnt_w(CLK_DIV, 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_phase_en,
  output logic o_half_tick,
  output logic o_phase
);

  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_cnt_d;
  logic             r_phase;
  logic             w_phase_d;
  logic             w_half_tick;

  assign w_half_tick = i_en && (r_div_cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    w_div_cnt_d = r_div_cnt;
    w_phase_d   = r_phase;
    if (!i_en) begin
      w_div_cnt_d = '0;
      w_phase_d   = 1'b0;
    end else if (w_half_tick) begin
      w_div_cnt_d = '0;
      // Phase is frozen while latching so s_clk stays low through LATCH.
      if (i_phase_en) begin
        w_phase_d = ~r_phase;
      end
    end else begin
      w_div_cnt_d = r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
      r_phase   <= w_phase_d;
    end
  end

  assign o_half_tick = w_half_tick;
  assign o_phase     = r_phase;

endmodule

// File: rtl/serial_shift_drv.sv
// Serial shift-out driver for external shift-register chains (7-seg and LED).
// Captures i_din on a rising edge of i_start, clocks it out on o_s_clk/o_s_dout
// at a divided rate, then raises o_s_pen to latch the chain.
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_start   frame request, rising edge detected internally
//   i_din     frame data, captured on the accepted edge
//   o_busy    frame in progress
//   o_done    one-cycle pulse at frame completion
//   o_s_clk   serial clock, data valid on its rising edge
//   o_s_dout  serial data
//   o_s_pen   latch / output enable, rising edge latches the chain
//   o_s_clrn  chain clear, active-low
// Optional build macro SERIAL_SHIFT_PENDING_EN: one-deep pending frame slot for
// start edges arriving while busy (last edge wins).
module serial_shift_drv
  import serial_shift_pkg::*;
#(
  parameter int unsigned DATA_W    = SsDefDataW,
  parameter int unsigned CLK_DIV   = SsDefClkDiv,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_s_clk,
  output logic              o_s_dout,
  output logic              o_s_pen,
  output logic              o_s_clrn
);

  localparam int unsigned CntW = ss_cnt_w(CLK_DIV, DATA_W);

  ss_state_e         r_state;
  ss_state_e         w_state_d;
  logic              r_start_q;
  logic [DATA_W-1:0] r_sreg;
  logic [DATA_W-1:0] w_sreg_d;
  logic [DATA_W-1:0] w_sreg_shift;
  logic [CntW-1:0]   r_bit_cnt;
  logic [CntW-1:0]   w_bit_cnt_d;
  logic              r_busy;
  logic              w_busy_d;
  logic              r_done;
  logic              w_done_d;
  logic              r_s_pen;
  logic              w_s_pen_d;
  logic              r_s_clrn;
  logic              w_edge;
  logic              w_half_tick;
  logic              w_phase;

`ifdef SERIAL_SHIFT_PENDING_EN
  logic              r_pend;
  logic              w_pend_d;
  logic [DATA_W-1:0] r_pend_din;
  logic [DATA_W-1:0] w_pend_din_d;
`endif

  assign w_edge = i_start & ~r_start_q;

  // The outgoing bit always sits at the head of the shift register.
  assign w_sreg_shift = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
  assign o_s_dout     = MSB_FIRST ? r_sreg[DATA_W-1] : r_sreg[0];

  serial_shift_tick #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CntW)
  ) u_tick (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (r_state != StIdle),
    .i_phase_en  (r_state == StShift),
    .o_half_tick (w_half_tick),
    .o_phase     (w_phase)
  );

  always_comb begin
    w_state_d   = r_state;
    w_sreg_d    = r_sreg;
    w_bit_cnt_d = r_bit_cnt;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_s_pen_d   = r_s_pen;
`ifdef SERIAL_SHIFT_PENDING_EN
    w_pend_d     = r_pend;
    w_pend_din_d = r_pend_din;
    if (w_edge && (r_state != StIdle)) begin
      w_pend_d     = 1'b1;
      w_pend_din_d = i_din;
    end
`endif
    unique case (r_state)
      StIdle: begin
        if (w_edge) begin
          w_state_d   = StShift;
          w_sreg_d    = i_din;
          w_bit_cnt_d = CntW'(DATA_W - 1);
          w_busy_d    = 1'b1;
          w_s_pen_d   = 1'b0;
        end
      end
      StShift: begin
        // Covers a frame launched straight from LATCH: pen must drop again
        // so the next completion produces a fresh rising edge.
        w_s_pen_d = 1'b0;
        // Advance on the high->low transition of s_clk.
        if (w_half_tick && w_phase) begin
          if (r_bit_cnt == '0) begin
            w_state_d = StLatch;
          end else begin
            w_sreg_d    = w_sreg_shift;
            w_bit_cnt_d = r_bit_cnt - 1'b1;
          end
        end
      end
      StLatch: begin
        if (w_half_tick) begin
          w_s_pen_d = 1'b1;
          w_done_d  = 1'b1;
`ifdef SERIAL_SHIFT_PENDING_EN
          // An edge in this very cycle is newer than anything already stored.
          if (r_pend || w_edge) begin
            w_state_d   = StShift;
            w_sreg_d    = w_edge ? i_din : r_pend_din;
            w_bit_cnt_d = CntW'(DATA_W - 1);
            w_pend_d    = 1'b0;
          end else begin
            w_state_d = StIdle;
            w_busy_d  = 1'b0;
          end
`else
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      // Loading the live level means a start held through reset is not an edge.
      r_start_q <= i_start;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_s_pen   <= 1'b0;
      r_s_clrn  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_start_q <= i_start;
      r_sreg    <= w_sreg_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_s_pen   <= w_s_pen_d;
      r_s_clrn  <= 1'b1;
    end
  end

`ifdef SERIAL_SHIFT_PENDING_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend     <= 1'b0;
      r_pend_din <= '0;
    end else begin
      r_pend     <= w_pend_d;
      r_pend_din <= w_pend_din_d;
    end
  end
`endif

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_s_clk  = w_phase;
  assign o_s_pen  = r_s_pen;
  assign o_s_clrn = r_s_clrn;

endmodule

// File: tb/tb_serial_shift_drv.sv
module tb_serial_shift_drv;

  localparam int DWA = 8;
  localparam int CDA = 2;
  localparam int LA  = 2 * CDA * DWA + CDA;  // frame length, config A/B
  localparam int LC  = 2 * 1 * 1 + 1;        // frame length, config C

`ifdef SERIAL_SHIFT_PENDING_EN
  localparam bit PendOn = 1'b1;
`else
  localparam bit PendOn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, b_start, c_start;
  logic [7:0] a_din, b_din;
  logic [0:0] c_din;
  logic a_busy, a_done, a_s_clk, a_s_dout, a_s_pen, a_s_clrn;
  logic b_busy, b_done, b_s_clk, b_s_dout, b_s_pen, b_s_clrn;
  logic c_busy, c_done, c_s_clk, c_s_dout, c_s_pen, c_s_clrn;

  serial_shift_drv #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_din(a_din), .o_busy(a_busy),
    .o_done(a_done), .o_s_clk(a_s_clk), .o_s_dout(a_s_dout), .o_s_pen(a_s_pen),
    .o_s_clrn(a_s_clrn));

  serial_shift_drv #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_din(b_din), .o_busy(b_busy),
    .o_done(b_done), .o_s_clk(b_s_clk), .o_s_dout(b_s_dout), .o_s_pen(b_s_pen),
    .o_s_clrn(b_s_clrn));

  serial_shift_drv #(.DATA_W(1), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_din(c_din), .o_busy(c_busy),
    .o_done(c_done), .o_s_clk(c_s_clk), .o_s_dout(c_s_dout), .o_s_pen(c_s_pen),
    .o_s_clrn(c_s_clrn));

  int checks   = 0;
  int failures = 0;

  // Bits seen on each rising s_clk, sampled on the falling system edge.
  bit   cap_a[$];
  bit   cap_b[$];
  bit   cap_c[$];
  logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;

  always @(negedge clk) begin
    if (!a_prev && a_s_clk) cap_a.push_back(a_s_dout);
    if (!b_prev && b_s_clk) cap_b.push_back(b_s_dout);
    if (!c_prev && c_s_clk) cap_c.push_back(c_s_dout);
    a_prev <= a_s_clk;
    b_prev <= b_s_clk;
    c_prev <= c_s_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame on config A. second_at > 0 raises start again so that the edge is
  // sampled at the second_at-th clock edge after the first accept edge.
  task automatic frame_a(input logic [7:0] d0, input int second_at, input logic [7:0] d1);
    int   done_n[$];
    int   exp_done[$];
    int   busy_low;
    int   horizon;
    int   last;
    logic [7:0] w;
    logic [7:0] words[2];
    exp_done.push_back(LA);
    if (second_at > 0) begin
      if (second_at > LA) exp_done.push_back(second_at + LA);
      else if (PendOn) exp_done.push_back(2 * LA);
    end
    last     = exp_done[exp_done.size() - 1];
    horizon  = last + 20;
    busy_low = 0;
    words[0] = d0;
    words[1] = d1;
    cap_a.delete();
    @(negedge clk) a_start = 1'b0;
    @(negedge clk) begin a_start = 1'b1; a_din = d0; end
    @(posedge clk); #1;
    chk("a_busy_on_accept", 64'(a_busy), 64'd1);
    for (int n = 1; n <= horizon; n++) begin
      @(negedge clk);
      if (n == second_at) begin
        a_start = 1'b1;
        a_din   = d1;
      end else begin
        a_start = 1'b0;
        a_din   = 8'($urandom);
      end
      @(posedge clk); #1;
      if (a_done) begin
        done_n.push_back(n);
        chk("a_pen_at_done", 64'(a_s_pen), 64'd1);
      end
      if (n < last && !a_busy) busy_low++;
      if (n == LA - 1) chk("a_pen_low_in_latch", 64'(a_s_pen), 64'd0);
      if (n == LA) chk("a_busy_after_first", 64'(a_busy), 64'(exp_done.size() > 1 && second_at <= LA));
    end
    chk("a_done_count", 64'(done_n.size()), 64'(exp_done.size()));
    for (int k = 0; k < exp_done.size() && k < done_n.size(); k++) begin
      chk($sformatf("a_done_time%0d", k), 64'(done_n[k]), 64'(exp_done[k]));
    end
    chk("a_busy_gap", 64'(busy_low), 64'd0);
    chk("a_rise_count", 64'(cap_a.size()), 64'(8 * exp_done.size()));
    for (int k = 0; k < exp_done.size(); k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j < cap_a.size()) w = {w[6:0], 1'(cap_a[k * 8 + j])};
      end
      chk($sformatf("a_word%0d", k), 64'(w), 64'(words[k]));
    end
  endtask

  // Single frame on config B (which=1, LSB first) or C (which=2, 1-bit).
  task automatic frame_bc(input int which, input logic [7:0] d);
    int   dw;
    int   len;
    int   done_n[$];
    int   busy_low;
    logic bsy, dn;
    logic [7:0] w;
    dw       = (which == 1) ? 8 : 1;
    len      = (which == 1) ? LA : LC;
    busy_low = 0;
    cap_b.delete();
    cap_c.delete();
    @(negedge clk) begin b_start = 1'b0; c_start = 1'b0; end
    @(negedge clk) begin
      if (which == 1) begin b_start = 1'b1; b_din = d; end
      else begin c_start = 1'b1; c_din = d[0]; end
    end
    @(posedge clk); #1;
    bsy = (which == 1) ? b_busy : c_busy;
    chk($sformatf("dut%0d_busy_on_accept", which), 64'(bsy), 64'd1);
    for (int n = 1; n <= len + 10; n++) begin
      @(negedge clk) begin
        b_start = 1'b0;
        c_start = 1'b0;
        b_din   = 8'($urandom);
        c_din   = 1'($urandom);
      end
      @(posedge clk); #1;
      bsy = (which == 1) ? b_busy : c_busy;
      dn  = (which == 1) ? b_done : c_done;
      if (dn) done_n.push_back(n);
      if (n < len && !bsy) busy_low++;
    end
    chk($sformatf("dut%0d_done_count", which), 64'(done_n.size()), 64'd1);
    if (done_n.size() > 0) chk($sformatf("dut%0d_done_time", which), 64'(done_n[0]), 64'(len));
    chk($sformatf("dut%0d_busy_gap", which), 64'(busy_low), 64'd0);
    if (which == 1) begin
      chk("b_rise_count", 64'(cap_b.size()), 64'(dw));
      w = '0;
      for (int j = 0; j < 8 && j < cap_b.size(); j++) w[j] = cap_b[j];
      chk("b_word_lsb_first", 64'(w), 64'(d));
    end else begin
      chk("c_rise_count", 64'(cap_c.size()), 64'(dw));
      if (cap_c.size() > 0) chk("c_bit", 64'(cap_c[0]), 64'(d[0]));
    end
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    rst     = 1'b1;
    a_start = 1'b1;  // held high through reset: must not count as an edge
    b_start = 1'b0;
    c_start = 1'b0;
    a_din   = 8'h00;
    b_din   = 8'h00;
    c_din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_s_clk", 64'(a_s_clk), 64'd0);
    chk("rst_s_dout", 64'(a_s_dout), 64'd0);
    chk("rst_s_pen", 64'(a_s_pen), 64'd0);
    chk("rst_s_clrn", 64'(a_s_clrn), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("clrn_after_release", 64'(a_s_clrn), 64'd1);
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_busy) busy_seen++;
    end
    chk("start_held_through_rst", 64'(busy_seen), 64'd0);

    // Directed frames.
    frame_a(8'hA5, -1, 8'h00);
    frame_bc(1, 8'hA5);
    frame_bc(2, 8'h01);
    frame_a(8'h3C, 10, 8'hFF);                          // edge while busy
    frame_a(8'($urandom), LA, 8'($urandom));            // edge in the done cycle

    // Reset in the middle of a frame.
    @(negedge clk) a_start = 1'b0;
    @(negedge clk) begin a_start = 1'b1; a_din = 8'($urandom); end
    repeat (16) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(a_busy), 64'd0);
    chk("midrst_done", 64'(a_done), 64'd0);
    chk("midrst_s_clk", 64'(a_s_clk), 64'd0);
    chk("midrst_s_dout", 64'(a_s_dout), 64'd0);
    chk("midrst_s_pen", 64'(a_s_pen), 64'd0);
    chk("midrst_s_clrn", 64'(a_s_clrn), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    repeat (LA + 10) begin
      @(posedge clk); #1;
      if (a_busy) busy_seen++;
      if (a_done) done_seen++;
    end
    chk("midrst_no_frame", 64'(busy_seen), 64'd0);
    chk("midrst_no_done", 64'(done_seen), 64'd0);

    // Random frames against the model.
    for (int i = 0; i < 4; i++) begin
      frame_a(8'($urandom), -1, 8'h00);
      frame_bc(1, 8'($urandom));
      frame_bc(2, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
